cpu_wb_master: RTL
==================

# cpu_wb_master

Bridges the multi-cycle CPU's memory/IO port (request level, address, write data, write enable) onto Wishbone master port 0 of the bus interconnect. Each CPU request becomes exactly one single-beat Wishbone transaction. The block stalls the CPU until the slave acknowledges. A watchdog terminates transactions to unmapped or unresponsive slaves and returns a fixed error word. The block runs on the 100 MHz system clock, the same clock as the interconnect.

## Interface
Parameters:
- TIMEOUT, 255: cycles with stb high and no ack before forced termination; legal range 1..65535.
- ERR_DATA, 32'hFFFF_FFFF: read data returned on timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- cpu_req  in  1  CPU access request (CPU_MIO); level, held until cpu_ready seen.
- cpu_we  in  1  1 = write, 0 = read (mem_w).
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, valid while cpu_ready=1.
- cpu_ready  out  1  transaction complete (drives MIO_ready).
- m_adr_o  out  32  Wishbone address.
- m_dat_o  out  32  Wishbone write data.
- m_dat_i  in  32  Wishbone read data.
- m_sel_o  out  4  byte selects; always 4'hF.
- m_we_o  out  1  Wishbone write enable.
- m_stb_o  out  1  Wishbone strobe.
- m_ack_i  in  1  Wishbone acknowledge.
- bus_err  out  1  sticky timeout flag.
- busy  out  1  high in BUS state.

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - If cpu_req=1, capture cpu_addr, cpu_wdata and cpu_we into m_adr_o, m_dat_o and m_we_o.
  - Clear the watchdog and go to BUS.
  - Outputs are registered, so the bus does not see CPU-side changes after capture.
- BUS:
  - m_stb_o=1.
  - m_ack_i=1 at an edge:
    - If the captured op is a read, latch m_dat_i into cpu_rdata; a write leaves cpu_rdata unchanged.
    - Drop stb and go to DONE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 with no ack:
    - cpu_rdata=ERR_DATA (read or write).
    - bus_err set to 1.
    - Drop stb and go to DONE.
  - Ack wins if ack and timeout occur in the same cycle.
- DONE:
  - cpu_ready=1.
  - Return to IDLE when cpu_req=0. A held cpu_req never launches a second transaction.
- m_ack_i is ignored outside BUS, and a stray ack has no effect.
- Bus outputs:
  - m_sel_o is constant 4'hF. m_adr_o is passed unmodified; the slaves decode it.
  - m_adr_o, m_dat_o and m_we_o hold their last values after a transaction. Only stb qualifies them.
- bus_err clears only on reset.

## Timing
- Reset (rst_n=0 at an edge) puts the block in IDLE with:
  - m_stb_o=0, m_we_o=0, m_adr_o=0, m_dat_o=0, m_sel_o=4'hF
  - cpu_ready=0, cpu_rdata=0, bus_err=0, busy=0
- Reset mid-BUS: stb drops at that edge. No ready is produced, and the slave must tolerate an abandoned cycle.
- Best-case latency with a zero-wait slave (ack combinational on stb):
  - cpu_req sampled at edge 0.
  - stb high in cycle 1 and ack sampled at edge 1.
  - cpu_ready=1 from edge 2.
  - Total: 2 cycles req-to-ready.
- An N-wait slave adds N cycles.
- Timeout path: stb stays high for exactly TIMEOUT cycles, then cpu_ready follows 1 cycle later.
- cpu_ready deasserts the cycle after cpu_req is seen low. The earliest next stb is 2 cycles after cpu_req rises again.
- cpu_rdata is stable from ready assertion until the next read completes.

## Test plan
- Zero-wait read: slave acks immediately with m_dat_i=32'h1234_5678, cpu_addr=32'h0000_0040 → m_adr_o=32'h40, m_we_o=0, stb high 1 cycle, cpu_ready at edge 2, cpu_rdata=32'h1234_5678.
- 3-wait write: cpu_we=1, cpu_addr=32'hFFFF_FF00, cpu_wdata=32'hA5 → stb high 4 cycles, m_dat_o=32'hA5, m_we_o=1, cpu_ready 1 cycle after the ack edge.
- Timeout: TIMEOUT=8, no ack, read → stb high exactly 8 cycles, cpu_rdata=32'hFFFF_FFFF, bus_err=1 and still set after a subsequent successful access.
- Held request: cpu_req held high 20 cycles after ready → exactly one stb pulse. Drop req for 1 cycle, raise again → second transaction issued.
- Reset mid-BUS: rst_n=0 on the 2nd stb cycle → next cycle stb=0, cpu_ready=0, all outputs at reset values. A late ack after reset leaves the state in IDLE.
- Stray ack in IDLE and DONE: no state change, cpu_rdata unchanged.

Source files
------------

// File: rtl/cpu_wb_master.sv
// cpu_wb_master: turns one CPU memory/IO request into one single-beat
// Wishbone cycle, stalls the CPU until ack, and terminates cycles to dead
// slaves with a watchdog that returns a fixed error word.
module cpu_wb_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  output logic        bus_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  // Watchdog value seen in the last permitted stb cycle.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [15:0] r_wdog;
  logic        w_capture;
  logic        w_ack;
  logic        w_tmo;

  assign m_sel_o = 4'hF;

  // State register; reset abandons any cycle in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and state-decoded outputs; ack beats a same-cycle timeout.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_ack     = 1'b0;
    w_tmo     = 1'b0;
    m_stb_o   = 1'b0;
    busy      = 1'b0;
    cpu_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          w_capture = 1'b1;
          w_next    = S_BUS;
        end
      end
      S_BUS: begin
        m_stb_o = 1'b1;
        busy    = 1'b1;
        if (m_ack_i) begin
          w_ack  = 1'b1;
          w_next = S_DONE;
        end else if (r_wdog == WD_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        cpu_ready = 1'b1;
        // Held request must not relaunch; wait for it to drop.
        if (!cpu_req) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, watchdog, read-data return and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      m_we_o    <= 1'b0;
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
      r_wdog    <= '0;
    end else begin
      if (w_capture) begin
        m_adr_o <= cpu_addr;
        m_dat_o <= cpu_wdata;
        m_we_o  <= cpu_we;
        r_wdog  <= '0;
      end
      if (w_ack) begin
        if (!m_we_o) cpu_rdata <= m_dat_i;
      end else if (w_tmo) begin
        cpu_rdata <= ERR_DATA;
        bus_err   <= 1'b1;
      end else if (r_state == S_BUS) begin
        r_wdog <= r_wdog + 16'd1;
      end
    end
  end

endmodule
